// File: rtl/audio_out_pkg.sv
// Shared constants and helpers for the audio PWM output path: midscale level,
// dither LFSR parameters and a signed saturation helper.
package audio_out_pkg;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;  // x^16 + x^14 + x^13 + x^11
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  function automatic int midscale(input int pwm_w);
    return 1 << (pwm_w - 1);
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int               w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_pwm_out_pwm_core.sv
// PWM carrier: free-running counter, wrap / period-start generation,
// period-boundary level load (with mute override) and registered compare.
module pwm_core
  import audio_out_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [PWM_W-1:0] level_in,
  input  logic             level_valid_in,
  input  logic             mute_in,
  output logic             wrap_out,
  output logic             pwm_out,
  output logic             period_start_out
);

  localparam logic [PWM_W-1:0] MID = PWM_W'(midscale(PWM_W));

  logic [PWM_W-1:0] count_q, count_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             pstart_q, pstart_d;

  always_comb begin
    wrap_out = (count_q == '1);
    count_d  = count_q + PWM_W'(1);
    active_d = active_q;
    if (wrap_out) begin
      if (mute_in)             active_d = MID;
      else if (level_valid_in) active_d = level_in;
    end
    // Compare against next count/level so pwm_out lines up with period_start_out.
    pwm_d    = (count_d < active_d);
    pstart_d = wrap_out;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_q  <= '0;
      active_q <= MID;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
    end
  end

  assign pwm_out          = pwm_q;
  assign period_start_out = pstart_q;

endmodule

// File: rtl/audio_pwm_out.sv
// Audio sample -> saturating pre-gain -> volume shift -> offset-binary PWM level.
// Optional LFSR dither before truncation when AUDIO_PWM_DITHER_EN is defined.
module audio_pwm_out
  import audio_out_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int PWM_W  = 8,
  parameter int VOL_W  = 3,
  parameter int GAIN_W = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic signed [IN_W-1:0] sample_in,
  input  logic                   sample_valid_in,
  input  logic [GAIN_W-1:0]      gain_in,
  input  logic [VOL_W-1:0]       vol_in,
  input  logic                   mute_in,
  input  logic                   status_clr_in,
  output logic                   pwm_out,
  output logic                   period_start_out,
  output logic                   overrun_out,
  output logic                   sat_out
);

  localparam int               GW  = IN_W + (1 << GAIN_W);
  localparam logic [PWM_W-1:0] MID = PWM_W'(midscale(PWM_W));

  logic [GAIN_W-1:0]    shift;
  logic signed [GW-1:0] g_wide;
  logic signed [63:0]   g_sat;
  logic                 sat_hit1;

  always_comb begin
    shift = gain_in;
    if (int'(gain_in) > IN_W - 1) shift = GAIN_W'(IN_W - 1);
    g_wide   = GW'(sample_in) <<< shift;
    g_sat    = sat_to_width(64'(g_wide), IN_W);
    sat_hit1 = sample_valid_in && (g_sat != 64'(g_wide));
  end

  logic             s1_valid_q;
  logic [PWM_W-1:0] t;
  logic             sat_hit2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) s1_valid_q <= 1'b0;
    else         s1_valid_q <= sample_valid_in;
  end

`ifdef AUDIO_PWM_DITHER_EN
  localparam int DW = IN_W - PWM_W;

  logic signed [IN_W-1:0] g_q;
  logic [DW-1:0]          dith_q;
  logic [LFSR_W-1:0]      lfsr_q;
  logic [IN_W:0]          g_sum;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      g_q    <= '0;
      dith_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (sample_valid_in) begin
      g_q    <= g_sat[IN_W-1:0];
      dith_q <= lfsr_q[DW-1:0];
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Dither is non-negative, so the only possible overflow is past the positive limit.
  always_comb begin
    g_sum    = {g_q[IN_W-1], g_q} + {{(PWM_W + 1){1'b0}}, dith_q};
    sat_hit2 = s1_valid_q && (g_sum[IN_W] != g_sum[IN_W-1]);
    if (g_sum[IN_W] != g_sum[IN_W-1]) t = {1'b0, {(PWM_W - 1){1'b1}}};
    else                              t = g_sum[IN_W-1 -: PWM_W];
  end
`else
  logic [PWM_W-1:0] t_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)              t_q <= '0;
    else if (sample_valid_in) t_q <= g_sat[IN_W-1 -: PWM_W];
  end

  assign t        = t_q;
  assign sat_hit2 = 1'b0;
`endif

  logic [VOL_W-1:0]        vshift;
  logic signed [PWM_W-1:0] a;
  logic [PWM_W-1:0]        level;

  always_comb begin
    vshift = ~vol_in;  // 2^VOL_W-1-vol
    a      = $signed(t) >>> vshift;
    level  = {~a[PWM_W-1], a[PWM_W-2:0]};
  end

  logic             wrap;
  logic [PWM_W-1:0] pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             ovr_q, ovr_d;
  logic             sat_q, sat_d;

  // A write on the wrap cycle is not an overrun: the load consumes the old value.
  always_comb begin
    pend_d      = s1_valid_q ? level : pend_q;
    pend_flag_d = s1_valid_q | (pend_flag_q & ~wrap);
    ovr_d       = (s1_valid_q & pend_flag_q & ~wrap) | (ovr_q & ~status_clr_in);
    sat_d       = sat_hit1 | sat_hit2 | (sat_q & ~status_clr_in);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_q      <= MID;
      pend_flag_q <= 1'b0;
      ovr_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      ovr_q       <= ovr_d;
      sat_q       <= sat_d;
    end
  end

  pwm_core #(
    .PWM_W(PWM_W)
  ) u_pwm_core (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .level_in        (pend_q),
    .level_valid_in  (pend_flag_q),
    .mute_in         (mute_in),
    .wrap_out        (wrap),
    .pwm_out         (pwm_out),
    .period_start_out(period_start_out)
  );

  assign overrun_out = ovr_q;
  assign sat_out     = sat_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Randomised + directed bench for audio_pwm_out against a per-period behavioural model.
module tb_audio_pwm_out;

  localparam int IN_W   = 16;
  localparam int PWM_W  = 8;
  localparam int VOL_W  = 3;
  localparam int GAIN_W = 4;
  localparam int PER    = 1 << PWM_W;
  localparam int MIDV   = PER / 2;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b0;
  logic signed [IN_W-1:0] sample_in = '0;
  logic                   sample_valid_in = 1'b0;
  logic [GAIN_W-1:0]      gain_in = '0;
  logic [VOL_W-1:0]       vol_in = '1;
  logic                   mute_in = 1'b0;
  logic                   status_clr_in = 1'b0;
  logic                   pwm_out;
  logic                   period_start_out;
  logic                   overrun_out;
  logic                   sat_out;

  audio_pwm_out #(
    .IN_W(IN_W), .PWM_W(PWM_W), .VOL_W(VOL_W), .GAIN_W(GAIN_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .gain_in         (gain_in),
    .vol_in          (vol_in),
    .mute_in         (mute_in),
    .status_clr_in   (status_clr_in),
    .pwm_out         (pwm_out),
    .period_start_out(period_start_out),
    .overrun_out     (overrun_out),
    .sat_out         (sat_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model state: level in use, pending level/flag, sticky flags.
  int m_act  = MIDV;
  int m_pend = MIDV;
  bit m_flag = 1'b0;
  bit m_ovr  = 1'b0;
  bit m_sat  = 1'b0;

  // Per-period stimulus plan.
  int p_n;
  int p_off[4];
  int p_smp[4];
  int p_gain[4];
  int p_vol  = 7;
  bit p_mute = 1'b0;
  bit p_clr  = 1'b0;

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_level(input int smp, input int gain, input int vol,
                                   output bit sat);
    longint g;
    int     sh;
    int     t;
    int     lim_hi;
    int     lim_lo;
    lim_hi = (1 << (IN_W - 1)) - 1;
    lim_lo = -(1 << (IN_W - 1));
    sh  = (gain > IN_W - 1) ? IN_W - 1 : gain;
    g   = longint'(smp) * (longint'(1) << sh);
    sat = 1'b0;
    if (g > lim_hi) begin g = lim_hi; sat = 1'b1; end
    if (g < lim_lo) begin g = lim_lo; sat = 1'b1; end
    t = floor_div(int'(g), 1 << (IN_W - PWM_W));
    return floor_div(t, 1 << ((1 << VOL_W) - 1 - vol)) + MIDV;
  endfunction

  task automatic clear_plan();
    p_n   = 0;
    p_clr = 1'b0;
  endtask

  task automatic add(input int off, input int smp, input int gain);
    if (p_n < 4) begin
      p_off[p_n]  = off;
      p_smp[p_n]  = smp;
      p_gain[p_n] = gain;
      p_n++;
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_pstart();
    int i;
    for (i = 0; i < 2 * PER; i++) begin
      if (period_start_out) break;
      step();
    end
    chk("sync_pstart_seen", (i < 2 * PER), 1);
  endtask

  // Runs one full period starting at the cycle where period_start_out is high.
  task automatic run_period(input string tag);
    int hi;
    int ps_cnt;
    int ps_pos;
    int late;
    bit has_late;
    bit s;
    int lvl;
    hi = 0; ps_cnt = 0; ps_pos = -1;
    for (int k = 0; k < PER; k++) begin
      sample_valid_in = 1'b0;
      status_clr_in   = (k == 0) && p_clr;
      if (k == 0)   vol_in  = VOL_W'(p_vol);
      if (k == 100) mute_in = p_mute;
      for (int j = 0; j < p_n; j++) begin
        if (p_off[j] == k) begin
          sample_in       = IN_W'(p_smp[j]);
          gain_in         = GAIN_W'(p_gain[j]);
          sample_valid_in = 1'b1;
        end
      end
      #4;
      hi += int'(pwm_out);
      if (period_start_out) begin
        ps_cnt++;
        if (ps_pos < 0) ps_pos = k;
      end
      step();
    end
    sample_valid_in = 1'b0;
    status_clr_in   = 1'b0;
    chk({tag, "_high"}, hi, m_act);
    chk({tag, "_pstart_cnt"}, ps_cnt, 1);
    chk({tag, "_pstart_pos"}, ps_pos, 0);

    if (p_clr) begin m_ovr = 1'b0; m_sat = 1'b0; end
    has_late = 1'b0;
    late     = 0;
    for (int j = 0; j < p_n; j++) begin
      lvl = ref_level(p_smp[j], p_gain[j], p_vol, s);
      if (s) m_sat = 1'b1;
      // Pending is written two cycles after the strobe; offset PER-2 lands on the wrap.
      if (p_off[j] + 1 < PER - 1) begin
        if (m_flag) m_ovr = 1'b1;
        m_pend = lvl;
        m_flag = 1'b1;
      end else begin
        has_late = 1'b1;
        late     = lvl;
      end
    end
    m_act  = p_mute ? MIDV : (m_flag ? m_pend : m_act);
    m_flag = 1'b0;
    if (has_late) begin m_pend = late; m_flag = 1'b1; end
    chk({tag, "_overrun"}, overrun_out, m_ovr);
    chk({tag, "_sat"}, sat_out, m_sat);
    $display("period %s: high=%0d next_level=%0d ovr=%0b sat=%0b", tag, hi, m_act, m_ovr, m_sat);
  endtask

  initial begin
    int o;
    logic signed [IN_W-1:0] rs;

    rst_in = 1'b0;
    repeat (3) step();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pstart", period_start_out, 0);
    chk("rst_overrun", overrun_out, 0);
    chk("rst_sat", sat_out, 0);
    rst_in = 1'b1;
    wait_pstart();

    clear_plan(); run_period("idle0");
    clear_plan(); run_period("idle1");

    clear_plan(); add(10, 32767, 0);  run_period("load_max");
    clear_plan(); add(10, -32768, 0); run_period("full_max");
    clear_plan();                     run_period("full_min");

    clear_plan(); add(20, 256, 8);    run_period("sat_load");
    clear_plan(); p_clr = 1'b1;       run_period("sat_clear");

    p_vol = 6;
    clear_plan(); add(10, 16384, 0);  run_period("vol6_load");
    p_vol = 0;
    clear_plan(); add(10, 16384, 0);  run_period("vol6_run");
    clear_plan();                     run_period("vol0_run");
    p_vol = 7;

    clear_plan(); p_clr = 1'b1; add(10, 8192, 0); add(50, -8192, 0); run_period("ovr_two");
    clear_plan(); p_clr = 1'b1;       run_period("ovr_second_used");

    clear_plan(); p_clr = 1'b1; add(PER - 2, 12800, 0); run_period("wrap_write");
    clear_plan();                     run_period("wrap_hold");
    clear_plan();                     run_period("wrap_use");
    clear_plan(); p_clr = 1'b1; add(10, 8192, 0); add(PER - 2, -8192, 0); run_period("wrap_both");
    clear_plan();                     run_period("wrap_both_a");
    clear_plan();                     run_period("wrap_both_b");

    p_mute = 1'b1;
    clear_plan(); p_clr = 1'b1; add(0, 32767, 4); run_period("mute_raise");
    clear_plan();                     run_period("muted");
    p_mute = 1'b0;
    clear_plan();                     run_period("unmuted_hold");

    for (int r = 0; r < 40; r++) begin
      clear_plan();
      p_vol  = $urandom_range(0, 7);
      p_mute = ($urandom_range(0, 4) == 0);
      p_clr  = ($urandom_range(0, 2) == 0);
      o = $urandom_range(0, 120);
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        if (o > PER - 2) break;
        rs = IN_W'($urandom);
        add(o, int'(rs), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1));
        o += $urandom_range(1, 70);
      end
      if (p_n > 0 && $urandom_range(0, 3) == 0) p_off[p_n-1] = PER - 2;
      run_period($sformatf("rand%0d", r));
    end

    // Set both sticky flags and force midscale, then reset mid-period.
    p_mute = 1'b1;
    clear_plan(); p_clr = 1'b1; add(10, 32767, 5); add(30, 100, 0); run_period("pre_reset");
    for (int k = 0; k < 50; k++) step();
    #4;
    chk("pre_reset_pwm", pwm_out, 1);
    chk("pre_reset_overrun", overrun_out, 1);
    #1;
    rst_in = 1'b0;
    #1;
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_overrun", overrun_out, 0);
    chk("midrst_sat", sat_out, 0);
    chk("midrst_pstart", period_start_out, 0);
    step();
    step();
    rst_in  = 1'b1;
    p_mute  = 1'b0;
    mute_in = 1'b0;
    m_act = MIDV; m_pend = MIDV; m_flag = 1'b0; m_ovr = 1'b0; m_sat = 1'b0;
    wait_pstart();
    clear_plan(); run_period("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
